// File: rtl/imem_fetch_arbiter.sv
// rtl/imem_fetch_arbiter.sv - round-robin shared IMEM fetch arbiter with per-core last-fetch buffers
module imem_fetch_arbiter #(
  parameter int NUM_SIMD_CORES  = 4,
  parameter int LOG2_SIMD_CORES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_SIMD_CORES-1:0]    fetch_req,
  input  logic [32*NUM_SIMD_CORES-1:0] instruction_fetch,
  output logic [32*NUM_SIMD_CORES-1:0] instruction_from_imem,
  output logic [NUM_SIMD_CORES-1:0]    instr_valid,
  output logic                         imem_ren,
  output logic [31:0]                  imem_addr,
  input  logic [31:0]                  imem_rdata
);

  // Per-core request bookkeeping and last-fetch buffers
  logic [NUM_SIMD_CORES-1:0]             pending_q, pending_d;
  logic [NUM_SIMD_CORES-1:0]             last_ok_q, last_ok_d;
  logic [NUM_SIMD_CORES-1:0][31:0]       last_addr_q, last_addr_d;
  logic [NUM_SIMD_CORES-1:0][31:0]       last_instr_q, last_instr_d;
  logic [LOG2_SIMD_CORES-1:0]            rr_ptr_q, rr_ptr_d;

  // Stage 1 travels alongside imem_ren/imem_addr; stage 2 lines up with imem_rdata.
  // The nc bits mark reads that saw a flush and therefore must not refill a buffer.
  logic                                  imem_ren_q, imem_ren_d;
  logic [31:0]                           imem_addr_q, imem_addr_d;
  logic                                  s1_vld_q, s1_vld_d;
  logic [LOG2_SIMD_CORES-1:0]            s1_id_q, s1_id_d;
  logic                                  s1_nc_q, s1_nc_d;
  logic                                  s2_vld_q, s2_vld_d;
  logic [LOG2_SIMD_CORES-1:0]            s2_id_q, s2_id_d;
  logic [31:0]                           s2_addr_q, s2_addr_d;
  logic                                  s2_nc_q, s2_nc_d;

  // Registered responses to the cores
  logic [NUM_SIMD_CORES-1:0]             valid_q, valid_d;
  logic [NUM_SIMD_CORES-1:0][31:0]       instr_q, instr_d;

  logic [NUM_SIMD_CORES-1:0]             eligible;
  logic [NUM_SIMD_CORES-1:0]             hit;
  logic [NUM_SIMD_CORES-1:0]             miss_cand;
  logic                                  gnt_found;
  logic [LOG2_SIMD_CORES-1:0]            gnt_idx;
  logic [LOG2_SIMD_CORES-1:0]            scan_idx;

  assign instruction_from_imem = instr_q;
  assign instr_valid           = valid_q;
  assign imem_ren              = imem_ren_q;
  assign imem_addr             = imem_addr_q;

  // Hit detection, round-robin miss grant, read pipeline and buffer refill
  always_comb begin
    pending_d    = pending_q;
    last_ok_d    = last_ok_q;
    last_addr_d  = last_addr_q;
    last_instr_d = last_instr_q;
    rr_ptr_d     = rr_ptr_q;
    imem_addr_d  = imem_addr_q;
    instr_d      = instr_q;
    valid_d      = '0;
    gnt_found    = 1'b0;
    gnt_idx      = '0;
    scan_idx     = '0;

    // A hit is answered straight from the buffer; flush forces it down the miss path.
    eligible = fetch_req & ~pending_q & ~valid_q;
    for (int i = 0; i < NUM_SIMD_CORES; i++) begin
      hit[i] = eligible[i] & last_ok_q[i] & ~flush &
               (instruction_fetch[i*32 +: 32] == last_addr_q[i]);
    end
    miss_cand = eligible & ~hit;

    for (int i = 0; i < NUM_SIMD_CORES; i++) begin
      if (hit[i]) begin
        valid_d[i] = 1'b1;
        instr_d[i] = last_instr_q[i];
      end
    end

    // First miss candidate at or after rr_ptr, wrapping
    for (int k = 0; k < NUM_SIMD_CORES; k++) begin
      scan_idx = LOG2_SIMD_CORES'((int'(rr_ptr_q) + k) % NUM_SIMD_CORES);
      if (!gnt_found && miss_cand[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end

    if (flush) begin
      last_ok_d = '0;
    end

    imem_ren_d = gnt_found;
    s1_vld_d   = gnt_found;
    s1_id_d    = gnt_idx;
    s1_nc_d    = flush;
    if (gnt_found) begin
      imem_addr_d        = instruction_fetch[int'(gnt_idx)*32 +: 32];
      pending_d[gnt_idx] = 1'b1;
      if (int'(gnt_idx) == NUM_SIMD_CORES-1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + 1'b1;
      end
    end

    s2_vld_d  = s1_vld_q;
    s2_id_d   = s1_id_q;
    s2_addr_d = imem_addr_q;
    s2_nc_d   = s1_nc_q | flush;

    // Miss completion: the granted core cannot be hitting now since it is pending
    if (s2_vld_q) begin
      valid_d[s2_id_q]      = 1'b1;
      instr_d[s2_id_q]      = imem_rdata;
      pending_d[s2_id_q]    = 1'b0;
      last_addr_d[s2_id_q]  = s2_addr_q;
      last_instr_d[s2_id_q] = imem_rdata;
      if (!(s2_nc_q | flush)) begin
        last_ok_d[s2_id_q] = 1'b1;
      end
    end
  end

  // State update; reset drops any read still in the pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      last_ok_q    <= '0;
      last_addr_q  <= '0;
      last_instr_q <= '0;
      rr_ptr_q     <= '0;
      imem_ren_q   <= 1'b0;
      imem_addr_q  <= '0;
      s1_vld_q     <= 1'b0;
      s1_id_q      <= '0;
      s1_nc_q      <= 1'b0;
      s2_vld_q     <= 1'b0;
      s2_id_q      <= '0;
      s2_addr_q    <= '0;
      s2_nc_q      <= 1'b0;
      valid_q      <= '0;
      instr_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      last_ok_q    <= last_ok_d;
      last_addr_q  <= last_addr_d;
      last_instr_q <= last_instr_d;
      rr_ptr_q     <= rr_ptr_d;
      imem_ren_q   <= imem_ren_d;
      imem_addr_q  <= imem_addr_d;
      s1_vld_q     <= s1_vld_d;
      s1_id_q      <= s1_id_d;
      s1_nc_q      <= s1_nc_d;
      s2_vld_q     <= s2_vld_d;
      s2_id_q      <= s2_id_d;
      s2_addr_q    <= s2_addr_d;
      s2_nc_q      <= s2_nc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb/tb_imem_fetch_arbiter.sv - directed self-checking bench for imem_fetch_arbiter
module tb_imem_fetch_arbiter;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [3:0]   fetch_req;
  logic [127:0] ifetch;
  logic [127:0] ifi;
  logic [3:0]   instr_valid;
  logic         imem_ren;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_rdata;

  int errs  = 0;
  int total = 0;

  imem_fetch_arbiter #(.NUM_SIMD_CORES(4), .LOG2_SIMD_CORES(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush                 (flush),
    .fetch_req             (fetch_req),
    .instruction_fetch     (ifetch),
    .instruction_from_imem (ifi),
    .instr_valid           (instr_valid),
    .imem_ren              (imem_ren),
    .imem_addr             (imem_addr),
    .imem_rdata            (imem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected IMEM contents
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Single-port IMEM with one-cycle read latency
  always @(posedge clk) begin
    if (imem_ren) imem_rdata <= imem_word(imem_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic [31:0] a);
    ifetch[c*32 +: 32] = a;
    fetch_req[c] = 1'b1;
  endtask

  logic [31:0] seen [4];
  int n;

  initial begin
    rst = 1'b1; flush = 1'b0; fetch_req = '0; ifetch = '0; imem_rdata = '0;
    tick(); tick();
    check("rst_valid", 64'(instr_valid), 64'h0);
    check("rst_ren",   64'(imem_ren),    64'h0);
    check("rst_addr",  64'(imem_addr),   64'h0);
    check("rst_data",  64'(ifi[63:0]),   64'h0);
    rst = 1'b0;

    // Single miss from core 0
    set_req(0, 32'h100);
    tick();
    check("t1_ren",   64'(imem_ren),    64'h1);
    check("t1_addr",  64'(imem_addr),   64'h100);
    check("t1_nv1",   64'(instr_valid), 64'h0);
    tick();
    check("t1_nv2",   64'(instr_valid), 64'h0);
    check("t1_ren2",  64'(imem_ren),    64'h0);
    tick();
    check("t1_valid", 64'(instr_valid), 64'h1);
    check("t1_data",  64'(ifi[31:0]),   64'hDEADBEEF);
    fetch_req = '0;
    tick();

    // All four cores at once from rr_ptr=0
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 4; c++) set_req(c, 32'h200 + 32'(c*4));
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) check($sformatf("t2_addr%0d", c), 64'({imem_ren, imem_addr}), 64'({1'b1, 32'h200 + 32'((c-1)*4)}));
      if (c >= 3) begin
        check($sformatf("t2_valid%0d", c), 64'(instr_valid), 64'(4'b1 << (c-3)));
        check($sformatf("t2_data%0d", c), 64'(ifi[(c-3)*32 +: 32]), 64'(imem_word(32'h200 + 32'((c-3)*4))));
        fetch_req[c-3] = 1'b0;
      end
    end
    tick();
    check("t2_idle", 64'(imem_ren), 64'h0);

    // Core 2: miss on 0x100, then a buffer hit
    set_req(2, 32'h100);
    tick(); tick(); tick();
    check("t3_miss", 64'(instr_valid), 64'h4);
    fetch_req = '0;
    tick();
    set_req(2, 32'h100);
    tick();
    check("t3_hit",     64'(instr_valid),  64'h4);
    check("t3_hitdata", 64'(ifi[95:64]),   64'hDEADBEEF);
    check("t3_noren",   64'(imem_ren),     64'h0);
    fetch_req = '0;
    tick();

    // Flush coinciding with a hit-eligible request goes to IMEM
    set_req(2, 32'h100); flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fh_nohit", 64'(instr_valid),          64'h0);
    check("fh_ren",   64'({imem_ren, imem_addr}), 64'({1'b1, 32'h100}));
    tick(); tick();
    check("fh_valid", 64'(instr_valid), 64'h4);
    fetch_req = '0;
    tick();

    // Flush while core 1 miss is in flight
    set_req(1, 32'h300);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("t4_valid", 64'(instr_valid), 64'h2);
    check("t4_data",  64'(ifi[63:32]),  64'(imem_word(32'h300)));
    fetch_req = '0;
    tick();
    set_req(1, 32'h300);
    tick();
    check("t4_re_nohit", 64'(instr_valid),          64'h0);
    check("t4_re_ren",   64'({imem_ren, imem_addr}), 64'({1'b1, 32'h300}));
    tick(); tick();
    check("t4_re_valid", 64'(instr_valid), 64'h2);
    fetch_req = '0;
    tick();

    // Round-robin between cores 0 and 3 with continuous requests
    set_req(0, 32'h400); set_req(3, 32'h500);
    n = 0;
    for (int k = 0; k < 4; k++) seen[k] = '0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      tick();
      if (imem_ren) begin
        seen[n] = imem_addr;
        n++;
      end
      if (instr_valid[0]) ifetch[31:0]   = ifetch[31:0]   + 32'h4;
      if (instr_valid[3]) ifetch[127:96] = ifetch[127:96] + 32'h4;
    end
    check("t5_count", 64'(n),       64'd4);
    check("t5_g0",    64'(seen[0]), 64'h500);
    check("t5_g1",    64'(seen[1]), 64'h400);
    check("t5_g2",    64'(seen[2]), 64'h504);
    check("t5_g3",    64'(seen[3]), 64'h404);
    fetch_req = '0;
    repeat (5) tick();

    // Core 1 buffer is live before the reset test
    set_req(1, 32'h300);
    tick();
    check("t6_prehit", 64'(instr_valid), 64'h2);
    fetch_req = '0;
    tick();

    // Reset during T+2 of a miss
    set_req(1, 32'h600);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t6_valid", 64'(instr_valid), 64'h0);
    check("t6_ren",   64'(imem_ren),    64'h0);
    check("t6_addr",  64'(imem_addr),   64'h0);
    check("t6_data",  64'(ifi[63:32]),  64'h0);
    rst = 1'b0;
    fetch_req = '0;
    tick();
    set_req(1, 32'h300);
    tick();
    check("t6_lastok_clr", 64'(instr_valid),          64'h0);
    check("t6_miss_ren",   64'({imem_ren, imem_addr}), 64'({1'b1, 32'h300}));
    fetch_req = '0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
